// File: rtl/axi_read_qos_arbiter.sv
// ---------------------------------------------------------------------------
// axi_read_qos_arbiter
//
// Read-address arbiter with per-master QoS regulation. It sits between
// N_MASTERS AXI4 read masters and one shared slave AR port. It limits each
// master's reads in flight and its data beats per refill window. The
// latency-critical master PRIO_ID is exempt from the beat budget and wins
// arbitration whenever it is eligible. The R channel is only tapped, so that
// completed reads can be retired.
//
// Ports
//   clock, reset     rising-edge clock, asynchronous active-high reset
//   qos_enable       1: QoS limits and priority active, 0: plain round-robin
//   s_ar_valid/ready per-master AR handshake (ready is one-hot or zero)
//   s_ar_addr/len    per-master payload, master i at [i*W +: W]
//   m_ar_*           registered AR request towards the slave, id = master
//   r_valid/ready/last/id  R-channel tap used to retire outstanding reads
//   throttled        per-master: was valid but ineligible in the last cycle
//   cnt_err          sticky: a retire arrived for a master with nothing open
// ---------------------------------------------------------------------------
module axi_read_qos_arbiter #(
    parameter int N_MASTERS       = 4,
    parameter int ADDR_W          = 32,
    parameter int ID_W            = 2,
    parameter int MAX_OUTSTANDING = 16,
    parameter int BUDGET_BEATS    = 512,
    parameter int WINDOW_CYCLES   = 4096,
    parameter int PRIO_ID         = 0
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        qos_enable,
    input  logic [N_MASTERS-1:0]        s_ar_valid,
    output logic [N_MASTERS-1:0]        s_ar_ready,
    input  logic [N_MASTERS*ADDR_W-1:0] s_ar_addr,
    input  logic [N_MASTERS*8-1:0]      s_ar_len,
    output logic                        m_ar_valid,
    input  logic                        m_ar_ready,
    output logic [ADDR_W-1:0]           m_ar_addr,
    output logic [7:0]                  m_ar_len,
    output logic [ID_W-1:0]             m_ar_id,
    input  logic                        r_valid,
    input  logic                        r_ready,
    input  logic                        r_last,
    input  logic [ID_W-1:0]             r_id,
    output logic [N_MASTERS-1:0]        throttled,
    output logic                        cnt_err
);

    // One spare bit above the cap so that counting with QoS disabled can
    // run past MAX_OUTSTANDING without wrapping back to a small value.
    localparam int OC_W  = $clog2(MAX_OUTSTANDING + 1) + 1;
    localparam int BUD_W = $clog2(BUDGET_BEATS + 1);
    localparam int WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam int IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic [OC_W-1:0]  OC_CAP   = OC_W'(MAX_OUTSTANDING);
    localparam logic [OC_W-1:0]  OC_SAT   = {OC_W{1'b1}};
    localparam logic [BUD_W-1:0] BUD_FULL = BUD_W'(BUDGET_BEATS);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

    logic [0:0]           state_q, state_d;
    logic                 m_valid_q, m_valid_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [7:0]           len_q, len_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [IDX_W-1:0]     rr_q, rr_d;
    logic [WIN_W-1:0]     win_q, win_d;
    logic [N_MASTERS-1:0] throttled_q, throttled_d;
    logic                 cnt_err_q, cnt_err_d;

    logic [N_MASTERS-1:0] eligible;
    logic [N_MASTERS-1:0] err_hit;
    logic [IDX_W-1:0]     win_idx;
    logic [IDX_W-1:0]     cand_idx;
    logic                 win_found;
    logic                 prio_win;
    logic                 accept;
    logic                 retire;
    logic                 refill;

    // Reset gates the grant so no handshake can complete while reset is held.
    assign accept = (state_q == ST_IDLE) && win_found && !reset;
    assign retire = r_valid && r_ready && r_last && (int'(r_id) < N_MASTERS);
    assign refill = (win_q == WIN_LAST);

    // Per-master outstanding counter, beat budget and eligibility.
    generate
        for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_master
            localparam bit IS_PRIO = (gi == PRIO_ID);

            logic [OC_W-1:0]  oc_q, oc_d;
            logic [BUD_W-1:0] budget_q, budget_d, budget_base;
            logic [8:0]       beats;
            logic             inc, dec, budget_ok;

            assign beats = {1'b0, s_ar_len[gi*8 +: 8]} + 9'd1;

            // A full budget always admits one request, so bursts larger than
            // the whole budget still make progress once per window.
            assign budget_ok = IS_PRIO
                             || (int'(budget_q) >= int'(beats))
                             || (budget_q == BUD_FULL);

            assign eligible[gi] = s_ar_valid[gi]
                                & (~qos_enable | ((oc_q < OC_CAP) & budget_ok));

            assign inc             = accept && (win_idx == IDX_W'(gi));
            assign dec             = retire && (r_id == ID_W'(gi));
            assign err_hit[gi]     = dec && (oc_q == '0);
            assign s_ar_ready[gi]  = inc;
            assign throttled_d[gi] = s_ar_valid[gi] & ~eligible[gi];

            always_comb begin
                oc_d = oc_q;
                if (inc && !dec && (oc_q != OC_SAT)) begin
                    oc_d = oc_q + OC_W'(1);
                end else if (dec && !inc && (oc_q != '0)) begin
                    oc_d = oc_q - OC_W'(1);
                end

                // Refill replaces the budget rather than adding to it; an
                // accept in the refill cycle is charged against the new value.
                budget_base = refill ? BUD_FULL : budget_q;
                budget_d    = budget_base;
                if (inc) begin
                    budget_d = (int'(budget_base) > int'(beats))
                             ? budget_base - BUD_W'(beats) : '0;
                end
            end

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    oc_q     <= '0;
                    budget_q <= BUD_FULL;
                end else begin
                    oc_q     <= oc_d;
                    budget_q <= budget_d;
                end
            end
        end
    endgenerate

    // Winner: priority master first, then the first eligible master at or
    // after the round-robin pointer.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        prio_win  = 1'b0;
        cand_idx  = '0;
        if (qos_enable && eligible[PRIO_ID]) begin
            win_idx   = IDX_W'(PRIO_ID);
            win_found = 1'b1;
            prio_win  = 1'b1;
        end else begin
            for (int k = 0; k < N_MASTERS; k++) begin
                cand_idx = IDX_W'((int'(rr_q) + k) % N_MASTERS);
                if (!win_found && eligible[cand_idx]) begin
                    win_idx   = cand_idx;
                    win_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        m_valid_d = m_valid_q;
        addr_d    = addr_q;
        len_d     = len_q;
        id_d      = id_q;
        rr_d      = rr_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d   = ST_BUSY;
                    m_valid_d = 1'b1;
                    addr_d    = s_ar_addr[win_idx*ADDR_W +: ADDR_W];
                    len_d     = s_ar_len[win_idx*8 +: 8];
                    id_d      = ID_W'(win_idx);
                    // A priority grant does not consume the round-robin turn.
                    if (!prio_win) begin
                        rr_d = (int'(win_idx) == N_MASTERS - 1)
                             ? '0 : win_idx + IDX_W'(1);
                    end
                end
            end
            ST_BUSY: begin
                if (m_ar_ready) begin
                    state_d   = ST_IDLE;
                    m_valid_d = 1'b0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                m_valid_d = 1'b0;
            end
        endcase
        win_d     = refill ? '0 : win_q + WIN_W'(1);
        cnt_err_d = cnt_err_q | (|err_hit);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            m_valid_q   <= 1'b0;
            addr_q      <= '0;
            len_q       <= '0;
            id_q        <= '0;
            rr_q        <= '0;
            win_q       <= '0;
            throttled_q <= '0;
            cnt_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            m_valid_q   <= m_valid_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            id_q        <= id_d;
            rr_q        <= rr_d;
            win_q       <= win_d;
            throttled_q <= throttled_d;
            cnt_err_q   <= cnt_err_d;
        end
    end

    assign m_ar_valid = m_valid_q;
    assign m_ar_addr  = addr_q;
    assign m_ar_len   = len_q;
    assign m_ar_id    = id_q;
    assign throttled  = throttled_q;
    assign cnt_err    = cnt_err_q;

endmodule
